// File: rtl/iomem_pkg.sv
// Shared definitions for the iomem interconnect: FSM encoding, status word layout
// and the default peripheral page map.
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } iomem_state_e;

    // Status word layout: {count[15:0], last_slot[7:0], 7'b0, sticky}
    localparam int STAT_STICKY_BIT = 0;
    localparam int STAT_SLOT_LSB   = 8;
    localparam int STAT_CNT_LSB    = 16;

    localparam logic [7:0] PAGE_GPIO   = 8'h03;
    localparam logic [7:0] PAGE_AUDIO  = 8'h04;
    localparam logic [7:0] PAGE_VIDEO  = 8'h05;
    localparam logic [7:0] PAGE_SDCARD = 8'h06;
    localparam logic [7:0] PAGE_I2C    = 8'h07;

    function automatic logic [31:0] pack_status(input logic [15:0] cnt,
                                                input logic [7:0]  last_slot,
                                                input logic        sticky);
        logic [31:0] word;
        word                                = 32'h0000_0000;
        word[STAT_CNT_LSB +: 16]            = cnt;
        word[STAT_SLOT_LSB +: 8]            = last_slot;
        word[STAT_STICKY_BIT]               = sticky;
        return word;
    endfunction

endpackage

// File: rtl/iomem_timeout_ctr.sv
// Per-access WAIT timer, saturating timeout event counter, status fields and
// the one-cycle timeout interrupt pulse.
module iomem_timeout_ctr
    import iomem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wait_start,
    input  logic        wait_tick,
    input  logic        tmo_event,
    input  logic        stat_clr,
    input  logic [7:0]  slot,
    output logic        tmo_hit,
    output logic [31:0] status,
    output logic        irq_timeout
);

    localparam int TMR_W = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] timer_r;
    logic [CNT_W-1:0] cnt_r;
    logic [7:0]       last_slot_r;
    logic             sticky_r;
    logic             irq_r;

    // WAIT-cycle timer, restarted on every new slot access
    always_ff @(posedge clk) begin
        if (reset) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (wait_start) begin
            timer_r <= {TMR_W{1'b0}};
        end else if (wait_tick) begin
            timer_r <= timer_r + TMR_W'(1);
        end else begin
            timer_r <= timer_r;
        end
    end

    assign tmo_hit = (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

    // Status fields; the counter saturates instead of wrapping to zero
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r       <= {CNT_W{1'b0}};
            last_slot_r <= 8'h00;
            sticky_r    <= 1'b0;
        end else if (stat_clr) begin
            cnt_r       <= {CNT_W{1'b0}};
            last_slot_r <= 8'h00;
            sticky_r    <= 1'b0;
        end else if (tmo_event) begin
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
            last_slot_r <= slot;
            sticky_r    <= 1'b1;
        end else begin
            cnt_r       <= cnt_r;
            last_slot_r <= last_slot_r;
            sticky_r    <= sticky_r;
        end
    end

    // Interrupt pulse lines up with the m_ready of the aborted access
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= tmo_event;
        end
    end

    assign status      = pack_status(16'(cnt_r), last_slot_r, sticky_r);
    assign irq_timeout = irq_r;

endmodule

// File: rtl/iomem_interconnect.sv
// Page-decoded iomem interconnect with registered responses. Define
// IOMEM_TIMEOUT_EN to build the hung-peripheral timeout, status counters and irq.
module iomem_interconnect
    import iomem_pkg::*;
#(
    parameter int          N_SLOTS        = 8,
    parameter logic [7:0]  BASE_PAGE      = 8'h03,
    parameter logic [7:0]  STATUS_PAGE    = 8'hFF,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hFFFF_FFFF,
    parameter int          CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  m_valid,
    output logic                  m_ready,
    input  logic [3:0]            m_wstrb,
    input  logic [31:0]           m_addr,
    input  logic [31:0]           m_wdata,
    output logic [31:0]           m_rdata,
    output logic [N_SLOTS-1:0]    s_valid,
    input  logic [N_SLOTS-1:0]    s_ready,
    input  logic [32*N_SLOTS-1:0] s_rdata,
    output logic [3:0]            s_wstrb,
    output logic [31:0]           s_addr,
    output logic [31:0]           s_wdata,
    output logic                  irq_timeout
);

    localparam int SEL_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

    iomem_state_e       state_r, state_nxt_s;
    logic               m_ready_r, m_ready_nxt_s;
    logic [31:0]        m_rdata_r, m_rdata_nxt_s;
    logic [N_SLOTS-1:0] s_valid_r, s_valid_nxt_s;
    logic [SEL_W-1:0]   sel_r, sel_nxt_s;

    logic [7:0]         page_s, idx_s;
    logic               slot_hit_s, stat_hit_s;
    logic [N_SLOTS-1:0] dec_oh_s, sel_oh_s;
    logic [31:0]        sel_rdata_s;
    logic               sel_ready_s;

    logic               wait_start_s, wait_tick_s, tmo_event_s, stat_wr_s;
    logic               tmo_hit_s;
    logic [31:0]        status_s;

    assign s_wstrb = m_wstrb;
    assign s_addr  = m_addr;
    assign s_wdata = m_wdata;

    // Page decode; idx wraps below BASE_PAGE so low pages fall out as unmapped
    always_comb begin
        page_s     = m_addr[31:24];
        idx_s      = page_s - BASE_PAGE;
        slot_hit_s = ({1'b0, idx_s} < 9'(N_SLOTS));
        stat_hit_s = (page_s == STATUS_PAGE);
        dec_oh_s   = {N_SLOTS{1'b0}};
        for (int i = 0; i < N_SLOTS; i++) begin
            dec_oh_s[i] = (idx_s == 8'(i));
        end
    end

    // Return path mux for the slot latched at the start of the access
    always_comb begin
        sel_oh_s    = {N_SLOTS{1'b0}};
        sel_rdata_s = 32'h0000_0000;
        for (int i = 0; i < N_SLOTS; i++) begin
            sel_oh_s[i] = (sel_r == SEL_W'(i));
            sel_rdata_s = sel_rdata_s | (s_rdata[32*i +: 32] & {32{sel_oh_s[i]}});
        end
        sel_ready_s = |(s_ready & sel_oh_s);
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nxt_s   = state_r;
        m_ready_nxt_s = 1'b0;
        m_rdata_nxt_s = m_rdata_r;
        s_valid_nxt_s = {N_SLOTS{1'b0}};
        sel_nxt_s     = sel_r;
        wait_start_s  = 1'b0;
        wait_tick_s   = 1'b0;
        tmo_event_s   = 1'b0;
        stat_wr_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (m_valid && slot_hit_s) begin
                    state_nxt_s   = WAIT;
                    s_valid_nxt_s = dec_oh_s;
                    sel_nxt_s     = SEL_W'(idx_s);
                    wait_start_s  = 1'b1;
                end else if (m_valid && stat_hit_s) begin
                    state_nxt_s   = RESP;
                    m_ready_nxt_s = 1'b1;
                    m_rdata_nxt_s = status_s;
                    stat_wr_s     = |m_wstrb;
                end else if (m_valid) begin
                    state_nxt_s   = RESP;
                    m_ready_nxt_s = 1'b1;
                    m_rdata_nxt_s = 32'h0000_0000;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            WAIT: begin
                if (!m_valid) begin
                    state_nxt_s   = IDLE;
                end else if (sel_ready_s) begin
                    // a ready on the final timer cycle still wins over the timeout
                    state_nxt_s   = RESP;
                    m_ready_nxt_s = 1'b1;
                    m_rdata_nxt_s = sel_rdata_s;
                end else if (tmo_hit_s) begin
                    state_nxt_s   = RESP;
                    m_ready_nxt_s = 1'b1;
                    m_rdata_nxt_s = TIMEOUT_RDATA;
                    tmo_event_s   = 1'b1;
                end else begin
                    s_valid_nxt_s = s_valid_r;
                    wait_tick_s   = 1'b1;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            m_ready_r <= 1'b0;
            m_rdata_r <= 32'h0000_0000;
            s_valid_r <= {N_SLOTS{1'b0}};
            sel_r     <= {SEL_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            m_ready_r <= m_ready_nxt_s;
            m_rdata_r <= m_rdata_nxt_s;
            s_valid_r <= s_valid_nxt_s;
            sel_r     <= sel_nxt_s;
        end
    end

    assign m_ready = m_ready_r;
    assign m_rdata = m_rdata_r;
    assign s_valid = s_valid_r;

`ifdef IOMEM_TIMEOUT_EN
    iomem_timeout_ctr #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout_ctr (
        .clk         (clk),
        .reset       (reset),
        .wait_start  (wait_start_s),
        .wait_tick   (wait_tick_s),
        .tmo_event   (tmo_event_s),
        .stat_clr    (stat_wr_s),
        .slot        (8'(sel_r)),
        .tmo_hit     (tmo_hit_s),
        .status      (status_s),
        .irq_timeout (irq_timeout)
    );
`else
    // Without the timeout block WAIT never aborts and the status page reads zero
    localparam logic [31:0] unused_tmo_cfg = TIMEOUT_RDATA ^ 32'(TIMEOUT_CYCLES) ^ 32'(CNT_W);
    logic unused_tmo_ctl_s;
    assign unused_tmo_ctl_s = ^{wait_start_s, wait_tick_s, tmo_event_s, stat_wr_s};
    assign tmo_hit_s        = 1'b0;
    assign status_s         = 32'h0000_0000;
    assign irq_timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_interconnect.sv
// Directed, table-driven bench for iomem_interconnect with TIMEOUT_CYCLES=16;
// timeout-specific sequences follow the IOMEM_TIMEOUT_EN setting of the build.
`timescale 1ns/1ps
module tb_iomem_interconnect;

    localparam int N   = 8;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            m_valid;
    logic            m_ready;
    logic [3:0]      m_wstrb;
    logic [31:0]     m_addr;
    logic [31:0]     m_wdata;
    logic [31:0]     m_rdata;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [32*N-1:0] s_rdata;
    logic [3:0]      s_wstrb;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic            irq_timeout;

    logic [N-1:0]    rdy_mask;
    logic [N-1:0]    late_rdy;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign s_ready = (s_valid & rdy_mask) | late_rdy;

    iomem_interconnect #(
        .N_SLOTS        (N),
        .BASE_PAGE      (8'h03),
        .STATUS_PAGE    (8'hFF),
        .TIMEOUT_CYCLES (TMO),
        .TIMEOUT_RDATA  (32'hFFFF_FFFF),
        .CNT_W          (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_wstrb     (m_wstrb),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .s_wstrb     (s_wstrb),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .irq_timeout (irq_timeout)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [7:0]  rdy;
        logic [31:0] exp_rd;
        int          exp_lat;
        logic [7:0]  exp_sv;
        int          exp_svc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one access from a negedge; m_valid held until m_ready or budget cycles.
    task automatic access(input logic [31:0] addr, input logic [3:0] wstrb,
                          input logic [7:0] late_mask, input int late_cyc, input int budget,
                          output logic got, output logic [31:0] rd, output int lat,
                          output logic [7:0] sv_or, output int sv_cyc, output int irq_n,
                          output logic clean);
        m_addr  = addr;
        m_wstrb = wstrb;
        m_wdata = ~addr;
        m_valid = 1'b1;
        got = 1'b0; rd = 32'h0; lat = 0; sv_or = 8'h00; sv_cyc = 0; irq_n = 0;
        while (!got && lat < budget) begin
            @(posedge clk); @(negedge clk);
            lat++;
            sv_or = sv_or | s_valid;
            if (s_valid != 8'h00) sv_cyc++;
            if (irq_timeout) irq_n++;
            if (m_ready) begin
                got = 1'b1;
                rd  = m_rdata;
            end else if (lat == late_cyc) begin
                late_rdy = late_mask;
            end
        end
        m_valid = 1'b0;
        m_wstrb = 4'h0;
        @(posedge clk); @(negedge clk);
        if (irq_timeout) irq_n++;
        clean    = !m_ready && (s_valid == 8'h00);
        late_rdy = 8'h00;
    endtask

    vec_t        vecs[8];
    logic        got, clean;
    logic [31:0] rd;
    int          lat, sv_cyc, irq_n;
    logic [7:0]  sv_or;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0400_0000, 4'h0, 8'h02, 32'h1234_5678, 2, 8'h02, 1};
        vecs[1] = '{32'h2000_0000, 4'hF, 8'h00, 32'h0000_0000, 1, 8'h00, 0};
        vecs[2] = '{32'h0300_0010, 4'h0, 8'h01, 32'hA5A5_0000, 2, 8'h01, 1};
        vecs[3] = '{32'h0A00_00FC, 4'h0, 8'h80, 32'h7777_0007, 2, 8'h80, 1};
        vecs[4] = '{32'h0B00_0000, 4'h0, 8'hFF, 32'h0000_0000, 1, 8'h00, 0};
        vecs[5] = '{32'h0200_0000, 4'h0, 8'hFF, 32'h0000_0000, 1, 8'h00, 0};
        vecs[6] = '{32'hFF00_0000, 4'h0, 8'h00, 32'h0000_0000, 1, 8'h00, 0};
        vecs[7] = '{32'h0500_0004, 4'h3, 8'h04, 32'hCAFE_0002, 2, 8'h04, 1};

        s_rdata = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h0BAD_0004,
                   32'hDEAD_0003, 32'hCAFE_0002, 32'h1234_5678, 32'hA5A5_0000};
        reset = 1'b1; m_valid = 1'b0; m_wstrb = 4'h0; m_addr = 32'h0612_3456;
        m_wdata = 32'h0BEE_F00D; rdy_mask = 8'h00; late_rdy = 8'h00;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_ready", 32'(m_ready), 32'h0);
        chk("rst_m_rdata", m_rdata, 32'h0);
        chk("rst_s_valid", 32'(s_valid), 32'h0);
        chk("rst_irq", 32'(irq_timeout), 32'h0);
        chk("bcast_addr", s_addr, 32'h0612_3456);
        chk("bcast_wdata", s_wdata, 32'h0BEE_F00D);
        reset = 1'b0;
        @(posedge clk); @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            rdy_mask = vecs[i].rdy;
            access(vecs[i].addr, vecs[i].wstrb, 8'h00, -1, 20,
                   got, rd, lat, sv_or, sv_cyc, irq_n, clean);
            chk($sformatf("v%0d_got", i), 32'(got), 32'h1);
            chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_sv", i), 32'(sv_or), 32'(vecs[i].exp_sv));
            chk($sformatf("v%0d_svcyc", i), 32'(sv_cyc), 32'(vecs[i].exp_svc));
            chk($sformatf("v%0d_oneshot", i), 32'(clean), 32'h1);
        end

        // Reset in the middle of a WAIT on slot 3
        rdy_mask = 8'h00;
        m_addr = 32'h0600_0000; m_wstrb = 4'h0; m_valid = 1'b1;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        chk("rstw_sv_before", 32'(s_valid), 32'h08);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("rstw_sv", 32'(s_valid), 32'h0);
        chk("rstw_ready", 32'(m_ready), 32'h0);
        reset = 1'b0; m_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rdy_mask = 8'h01;
        access(32'h0300_0000, 4'h0, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("rstw_next_rd", rd, 32'hA5A5_0000);
        chk("rstw_next_lat", 32'(lat), 32'd2);

        // Slot 4 readies on the last timer cycle: data wins, no timeout
        rdy_mask = 8'h00;
        access(32'h0700_0000, 4'h0, 8'h10, TMO, 40, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("late_rd", rd, 32'h0BAD_0004);
        chk("late_lat", 32'(lat), 32'(TMO + 1));
        chk("late_svcyc", 32'(sv_cyc), 32'(TMO));
        chk("late_irq", 32'(irq_n), 32'h0);
        access(32'hFF00_0000, 4'h0, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("late_status", rd, 32'h0);

`ifdef IOMEM_TIMEOUT_EN
        // Hung slot 4 times out
        access(32'h0700_0000, 4'h0, 8'h00, -1, 40, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("tmo_got", 32'(got), 32'h1);
        chk("tmo_rd", rd, 32'hFFFF_FFFF);
        chk("tmo_lat", 32'(lat), 32'(TMO + 1));
        chk("tmo_irq", 32'(irq_n), 32'h1);
        chk("tmo_sv", 32'(sv_or), 32'h10);
        access(32'hFF00_0000, 4'h0, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("tmo_status", rd, 32'h0001_0401);

        // Abort in WAIT leaves status alone
        access(32'h0400_0000, 4'h0, 8'h00, -1, 5, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("abort_got", 32'(got), 32'h0);
        chk("abort_clean", 32'(clean), 32'h1);
        chk("abort_irq", 32'(irq_n), 32'h0);
        access(32'hFF00_0000, 4'h0, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("abort_status", rd, 32'h0001_0401);

        // Status write returns the old word and clears it
        access(32'hFF00_0000, 4'hF, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("clr_old", rd, 32'h0001_0401);
        access(32'hFF00_0000, 4'h0, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("clr_status", rd, 32'h0);
`else
        // Without the timeout a hung slot stalls until the master gives up
        access(32'h0700_0000, 4'h0, 8'h00, -1, 5000, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("hang_got", 32'(got), 32'h0);
        chk("hang_svcyc", 32'(sv_cyc), 32'd5000);
        chk("hang_irq", 32'(irq_n), 32'h0);
        chk("hang_abort_clean", 32'(clean), 32'h1);
        access(32'hFF00_0000, 4'hF, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("nostat_wr", rd, 32'h0);
        access(32'hFF00_0000, 4'h0, 8'h00, -1, 20, got, rd, lat, sv_or, sv_cyc, irq_n, clean);
        chk("nostat_rd", rd, 32'h0);
        chk("nostat_lat", 32'(lat), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
